// File: rtl/csa_slice_accum_if.sv
// Handshake bundle between the CSA stage, the slice accumulator and its consumer.
interface csa_slice_accum_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_SLICES = 8
);
    localparam int unsigned OUT_WIDTH = WIDTH + NUM_SLICES;
    localparam int unsigned IDX_W     = $clog2(NUM_SLICES);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_result;
    logic [IDX_W-1:0]     slice_idx;

    // Environment side: feeds partial sums and consumes results.
    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_result, slice_idx
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_result, slice_idx
    );
endinterface

// File: rtl/csa_slice_accum.sv
// Shift-and-add of NUM_SLICES bit-slice partial sums into one dot-product result,
// with optional negative weight on the MSB slice for two's-complement inputs.
module csa_slice_accum #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_SLICES = 8,
    parameter int unsigned SIGNED     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    csa_slice_accum_if.slave   bus
);
    localparam int unsigned OUT_WIDTH = WIDTH + NUM_SLICES;
    localparam int unsigned IDX_W     = $clog2(NUM_SLICES);
    localparam int unsigned LAST      = NUM_SLICES - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                      state_q;
    logic signed [OUT_WIDTH-1:0] acc_q;
    logic signed [OUT_WIDTH-1:0] acc_d;
    logic signed [OUT_WIDTH-1:0] sext;
    logic signed [OUT_WIDTH-1:0] term;
    logic        [OUT_WIDTH-1:0] out_result_q;
    logic        [IDX_W-1:0]     slice_idx_q;
    logic                        out_valid_q;
    logic                        in_ready_q;
    logic                        is_last;

    // Weighted term for the slice being offered; slice 0 restarts the sum.
    always_comb begin
        sext    = OUT_WIDTH'($signed(bus.in_sum));
        term    = sext <<< slice_idx_q;
        is_last = (slice_idx_q == IDX_W'(LAST));
        acc_d   = acc_q + term;
        if (slice_idx_q == '0) begin
            acc_d = term;
        end else if ((SIGNED != 0) && is_last) begin
            acc_d = acc_q - term;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            slice_idx_q  <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            // Abort wins over any same-cycle accept or output handshake.
            state_q      <= IDLE;
            acc_q        <= '0;
            slice_idx_q  <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (bus.in_valid && in_ready_q) begin
                        acc_q <= acc_d;
                        if (is_last) begin
                            state_q      <= DONE;
                            slice_idx_q  <= '0;
                            out_result_q <= acc_d;
                            out_valid_q  <= 1'b1;
                            in_ready_q   <= 1'b0;
                        end else begin
                            state_q     <= ACCUM;
                            slice_idx_q <= slice_idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.slice_idx  = slice_idx_q;
endmodule

// File: tb/tb_csa_slice_accum.sv
// Bench for csa_slice_accum: signed and unsigned instances share one stimulus stream.
module tb_csa_slice_accum;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_sum;
    logic        out_ready;

    csa_slice_accum_if #(.WIDTH(16), .NUM_SLICES(8)) ifa ();
    csa_slice_accum_if #(.WIDTH(16), .NUM_SLICES(8)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_sum    = in_sum;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_sum    = in_sum;
    assign ifb.out_ready = out_ready;

    csa_slice_accum #(.WIDTH(16), .NUM_SLICES(8), .SIGNED(1)) u_signed (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifa.slave)
    );
    csa_slice_accum #(.WIDTH(16), .NUM_SLICES(8), .SIGNED(0)) u_unsigned (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][15:0] s;
        logic [23:0]      exp_s;
        logic [23:0]      exp_u;
    } vec_t;

    typedef struct packed {
        logic [23:0] s;
        logic [23:0] u;
    } exp_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            e = sb.pop_front();
            chk({name, " out_valid"}, 32'(ifa.out_valid), 32'd1);
            chk({name, " signed"},    32'(ifa.out_result), 32'(e.s));
            chk({name, " unsigned"},  32'(ifb.out_result), 32'(e.u));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{s: {8{16'h0001}}, exp_s: 24'hFFFFFF, exp_u: 24'h0000FF};
        vecs[1] = '{s: {8{16'h8000}}, exp_s: 24'h008000, exp_u: 24'h808000};
        vecs[2] = '{s: {8{16'h7FFF}}, exp_s: 24'hFF8001, exp_u: 24'h7F7F01};
        vecs[3] = '{s: {16'h0001, {7{16'h0000}}}, exp_s: 24'hFFFF80, exp_u: 24'h000080};
        vecs[4] = '{s: {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                    exp_s: 24'hFFFF01, exp_u: 24'h000701};
        vecs[5] = '{s: {8{16'h0002}}, exp_s: 24'hFFFFFE, exp_u: 24'h0001FE};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset out_valid",  32'(ifa.out_valid),  32'd0);
        chk("reset out_result", 32'(ifa.out_result), 32'd0);
        chk("reset in_ready",   32'(ifa.in_ready),   32'd1);
        chk("reset slice_idx",  32'(ifa.slice_idx),  32'd0);
        @(negedge clk); rst = 1'b0;
        tick;

        // Back-to-back vectors; result must appear right after the final accept, for one cycle.
        for (int v = 0; v < NV; v++) begin
            sb.push_back('{s: vecs[v].exp_s, u: vecs[v].exp_u});
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("vec%0d idx%0d", v, k), 32'(ifa.slice_idx), 32'(k));
                chk($sformatf("vec%0d early valid%0d", v, k), 32'(ifa.out_valid), 32'd0);
                send(vecs[v].s[k]);
            end
            check_result($sformatf("vec%0d", v));
            chk($sformatf("vec%0d in_ready in DONE", v), 32'(ifa.in_ready), 32'd0);
            tick;
            chk($sformatf("vec%0d valid one cycle", v), 32'(ifa.out_valid), 32'd0);
            chk($sformatf("vec%0d in_ready after", v),  32'(ifa.in_ready),  32'd1);
        end

        // Random bubbles between slices leave slice_idx untouched.
        sb.push_back('{s: 24'd3, u: 24'd3});
        for (int k = 0; k < 8; k++) begin
            int nb;
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                tick;
                chk($sformatf("bubble idx%0d", k), 32'(ifa.slice_idx), 32'(k));
            end
            send((k == 0) ? 16'd3 : 16'd0);
            chk($sformatf("bubble post idx%0d", k), 32'(ifa.slice_idx), 32'((k + 1) % 8));
        end
        check_result("bubbles");
        tick;

        // Backpressure: result held, upstream held off.
        out_ready = 1'b0;
        sb.push_back('{s: 24'hFFFFFF, u: 24'h0000FF});
        for (int k = 0; k < 8; k++) send(16'd1);
        check_result("bp");
        in_valid = 1'b1; in_sum = 16'd7;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk($sformatf("bp hold valid%0d", c),  32'(ifa.out_valid),  32'd1);
            chk($sformatf("bp hold result%0d", c), 32'(ifa.out_result), 32'hFFFFFF);
            chk($sformatf("bp hold ready%0d", c),  32'(ifa.in_ready),   32'd0);
            chk($sformatf("bp hold idx%0d", c),    32'(ifa.slice_idx),  32'd0);
        end
        out_ready = 1'b1;
        tick;
        chk("bp release valid", 32'(ifa.out_valid), 32'd0);
        chk("bp release idx",   32'(ifa.slice_idx), 32'd0);
        tick;
        in_valid = 1'b0;
        chk("bp accept 7 idx", 32'(ifa.slice_idx), 32'd1);
        sb.push_back('{s: 24'd7, u: 24'd7});
        for (int k = 1; k < 8; k++) send(16'd0);
        check_result("bp next");
        tick;

        // Flush wins over the accept of slice 4.
        for (int k = 0; k < 4; k++) send(16'd9);
        in_valid = 1'b1; in_sum = 16'd9; flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush idx",      32'(ifa.slice_idx), 32'd0);
        chk("flush valid",    32'(ifa.out_valid), 32'd0);
        chk("flush in_ready", 32'(ifa.in_ready),  32'd1);
        sb.push_back('{s: 24'hFFFFFE, u: 24'h0001FE});
        for (int k = 0; k < 8; k++) send(16'd2);
        check_result("after flush");
        tick;

        // Flush in DONE beats the out_ready handshake and drops the result.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(16'd1);
        out_ready = 1'b1; flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush DONE valid",    32'(ifa.out_valid), 32'd0);
        chk("flush DONE in_ready", 32'(ifa.in_ready),  32'd1);
        chk("flush DONE idx",      32'(ifa.slice_idx), 32'd0);

        // Asynchronous reset mid-accumulation.
        for (int k = 0; k < 5; k++) send(16'd5);
        chk("pre-rst idx", 32'(ifa.slice_idx), 32'd5);
        in_valid = 1'b1; in_sum = 16'd5;
        #2 rst = 1'b1;
        #1;
        chk("arst accum idx",    32'(ifa.slice_idx),  32'd0);
        chk("arst accum ready",  32'(ifa.in_ready),   32'd1);
        chk("arst accum valid",  32'(ifa.out_valid),  32'd0);
        chk("arst accum result", 32'(ifa.out_result), 32'd0);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        tick;

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(16'd1);
        chk("pre-rst DONE valid", 32'(ifa.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst DONE valid",  32'(ifa.out_valid),  32'd0);
        chk("arst DONE result", 32'(ifa.out_result), 32'd0);
        chk("arst DONE ready",  32'(ifa.in_ready),   32'd1);
        chk("arst DONE idx",    32'(ifa.slice_idx),  32'd0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_slice_accum.md
Name: csa_slice_accum

Overview:
- Downstream consumer of the pipelined CSA stage in the DPE datapath.
- The input vector is presented to the CSA stage one bit-slice per pass, LSB slice first. Each pass yields one WIDTH-bit partial dot-product sum.
- This block shift-and-adds NUM_SLICES consecutive partial sums into one full-precision dot-product result. The result is presented on a valid/ready output.
- It also applies two's-complement weighting to the MSB slice when SIGNED=1.

Parameters:
WIDTH, 16, width of each incoming partial sum (matches CSA output width)
NUM_SLICES, 8, number of bit-slices (passes) per dot product; >=2
SIGNED, 1, 1 = MSB slice has negative weight (two's-complement inputs); 0 = all slices positive
OUT_WIDTH, WIDTH+NUM_SLICES, result width (derived; do not override)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous abort of the partial accumulation
in_valid  input  1  partial sum on in_sum is valid
in_ready  output  1  block can accept a partial sum this cycle
in_sum  input  WIDTH  partial sum from CSA stage; two's complement, sign-extended internally
out_valid  output  1  result on out_result is valid
out_ready  input  1  downstream accepts result
out_result  output  OUT_WIDTH  accumulated dot-product result, two's complement
slice_idx  output  $clog2(NUM_SLICES)  index of the next slice expected (0..NUM_SLICES-1)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=0, slice_idx=0.
  - out_valid=0, out_result=0, in_ready=1.
  - Applies immediately, mid-operation included; partial work is discarded.
- States:
  - IDLE: no partial in progress; in_ready=1.
  - ACCUM: slices 1..NUM_SLICES-1 pending; in_ready=1.
  - DONE: result held; in_ready=0, out_valid=1.
- Accept: in_valid && in_ready on a rising edge.
- Accept of slice k:
  - term = sext(in_sum) << k, computed in OUT_WIDTH bits.
  - If SIGNED=1 and k=NUM_SLICES-1: acc_next = acc - term; otherwise acc_next = acc + term.
  - For k=0, acc_next = term; the prior acc is ignored.
- Transitions:
  - IDLE --accept--> ACCUM, slice_idx=1.
  - ACCUM --accept, k<NUM_SLICES-1--> ACCUM, slice_idx=k+1.
  - ACCUM --accept, k=NUM_SLICES-1--> DONE, slice_idx=0, out_result=acc_next.
  - DONE --out_ready--> IDLE, out_valid=0.
- Latency: out_valid rises the cycle after the final slice is accepted. Minimum throughput is NUM_SLICES+1 cycles per result.
- Output hold: while out_valid=1 and out_ready=0, out_result and out_valid are stable.
- out_result is registered and only updates on entry to DONE; otherwise it keeps its last value.
- Bubbles: in_valid=0 cycles in IDLE/ACCUM leave acc and slice_idx unchanged. There is no timeout.
- In DONE, in_valid is ignored (in_ready=0); upstream must hold its data.
- flush=1 (synchronous):
  - Next state IDLE, acc=0, slice_idx=0, out_valid=0.
  - Flush has priority over a same-cycle accept and over an out_ready handshake.
  - A flushed result in DONE is lost.
- Width: OUT_WIDTH = WIDTH+NUM_SLICES is exact for all inputs; no overflow or saturation logic.
- in_ready is a function of state only, with no combinational path from out_ready.

Test Plan:
1. WIDTH=16, NUM_SLICES=8, SIGNED=1; in_sum=1 on all 8 slices back-to-back, out_ready=1 -> out_result=24'hFFFFFF (-1). out_valid for exactly 1 cycle, at cycle 9 after the first accept.
2. in_sum=-32768 on all 8 slices, SIGNED=1 -> out_result=24'h008000 (+32768). Same stimulus with SIGNED=0 -> out_result=-32768*255=24'h808000.
3. Slice 0 = 3, slices 1..7 = 0, with random in_valid bubbles between slices -> out_result=3; slice_idx increments only on accepts.
4. Backpressure:
   - After the final slice, hold out_ready=0 for 5 cycles while in_valid=1 with in_sum=7 -> out_valid and out_result stable, in_ready=0, nothing accepted.
   - Raise out_ready -> return to IDLE; the next accept is slice 0 with value 7.
5. flush asserted together with the accept of slice 4 -> slice_idx=0, no out_valid. The following 8 slices of value 2 give out_result=2*(127-128)=-2=24'hFFFFFE.
6. Assert rst asynchronously (mid-cycle) during slice 5, and again while in DONE with out_ready=0 -> out_valid=0, out_result=0, slice_idx=0, in_ready=1 immediately, before the next clock edge.
